sll_iter: RTL and testbench

- Multicycle logical left shifter for the ALU/multdiv side of the CPU: the left-direction counterpart of the combinational arithmetic right shifter.
- Applies the same 16/8/4/2/1 conditional-stage decomposition, one stage per clock, reusing a single stage instance.
- Uses a ctrl/RDY handshake matching the multdiv unit, so the pipeline can stall on it identically.
- Also reports whether any 1 bits were shifted out of bit 31.

---
 rtl/sll_iter_pkg.sv | 20 ++
 rtl/sll_stage.sv | 38 +++
 rtl/sll_iter.sv | 127 ++++++++++++
 tb/tb_sll_iter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sll_iter_pkg.sv
// -----------------------------------------------------------------------------
// sll_iter_pkg
//   Shared definitions for the multicycle logical left shifter.
//   - state_t        : FSM state encoding (IDLE / SHIFT)
//   - WIDTH_DEF      : default datapath width
//   - SHAMT_W_DEF    : default shift-amount width
//   - NUM_STAGES     : number of conditional shift stages (one per amount bit)
// -----------------------------------------------------------------------------
package sll_iter_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;
  localparam int NUM_STAGES  = SHAMT_W_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : sll_iter_pkg

// File: rtl/sll_stage.sv
// -----------------------------------------------------------------------------
// sll_stage
//   One conditional stage of the left shifter, reused on every cycle of an
//   operation. Purely combinational.
//   Ports:
//     in   : value entering the stage
//     k    : stage index; the stage shifts by 2^k
//     en   : stage enable (the matching bit of the shift amount)
//     out  : en ? in << 2^k : in   (zero filled from the LSB)
//     lost : en and at least one 1 bit left the top of the word
// -----------------------------------------------------------------------------
module sll_stage
  import sll_iter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int K_W   = 3
) (
  input  logic [WIDTH-1:0] in,
  input  logic [K_W-1:0]   k,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             lost
);

  logic [31:0]      sh;
  logic [WIDTH-1:0] top_mask;

  // NOTE: every output of a combinational block is assigned on every path;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    sh       = 32'd1 << k;
    // The top 2^k bits are the ones this stage pushes out of the word.
    top_mask = ~({WIDTH{1'b1}} >> sh);
    out      = en ? (in << sh) : in;
    lost     = en & (|(in & top_mask));
  end

endmodule : sll_stage

// File: rtl/sll_iter.sv
// -----------------------------------------------------------------------------
// sll_iter
//   Multicycle logical left shifter. The shift amount is applied as 16/8/4/2/1
//   conditional stages, one per clock, through a single shared sll_stage.
//   Every operation takes exactly SHAMT_W clocks from acceptance to the
//   data_resultRDY pulse, independent of the amount.
//   Ports:
//     clock          : clock, rising edge
//     reset          : asynchronous, active-high reset
//     ctrl_shift     : start strobe; also restarts an operation in flight
//     A              : operand, sampled only when ctrl_shift is accepted
//     shft_amount    : shift count, sampled with A
//     data_result    : A << shft_amount, held until the next completion
//     data_exception : a 1 bit was shifted out of the top; held with result
//     data_resultRDY : one-cycle pulse when result/exception update
//     busy           : an operation is in flight
// -----------------------------------------------------------------------------
module sll_iter
  import sll_iter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shft_amount,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);

  state_t             state, state_n;
  logic [WIDTH-1:0]   acc, acc_n;
  logic [SHAMT_W-1:0] amt, amt_n;
  logic [K_W-1:0]     k, k_n;
  logic               ovf, ovf_n;
  logic [WIDTH-1:0]   result_n;
  logic               exception_n;
  logic               rdy_n;
  logic               busy_n;

  logic [WIDTH-1:0]   stage_out;
  logic               stage_lost;

  // Stages run from the largest (2^(SHAMT_W-1)) down to 1, so the counter
  // doubles as the index of the amount bit that enables this cycle's stage.
  sll_stage #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_stage (
    .in   (acc),
    .k    (k),
    .en   (amt[k]),
    .out  (stage_out),
    .lost (stage_lost)
  );

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    amt_n       = amt;
    k_n         = k;
    ovf_n       = ovf;
    result_n    = data_result;
    exception_n = data_exception;
    rdy_n       = 1'b0;
    busy_n      = busy;

    if (state == SHIFT) begin
      acc_n = stage_out;
      ovf_n = ovf | stage_lost;
      k_n   = k - 1'b1;
      if (k == '0) begin
        result_n    = stage_out;
        exception_n = ovf | stage_lost;
        rdy_n       = 1'b1;
        state_n     = IDLE;
        busy_n      = 1'b0;
      end
    end

    // A start wins over whatever the shift path computed: from IDLE it is a
    // normal accept, mid-operation it aborts, and on the final stage it
    // accepts alongside the completion (result/RDY above are kept).
    if (ctrl_shift) begin
      acc_n   = A;
      amt_n   = shft_amount;
      k_n     = K_LAST;
      ovf_n   = 1'b0;
      state_n = SHIFT;
      busy_n  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      acc            <= '0;
      amt            <= '0;
      k              <= '0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      acc            <= acc_n;
      amt            <= amt_n;
      k              <= k_n;
      ovf            <= ovf_n;
      data_result    <= result_n;
      data_exception <= exception_n;
      data_resultRDY <= rdy_n;
      busy           <= busy_n;
    end
  end

endmodule : sll_iter

// File: tb/tb_sll_iter.sv
// -----------------------------------------------------------------------------
// tb_sll_iter
//   Self-checking bench for sll_iter. Expected results are computed by a
//   64-bit reference shift when an operation is accepted, queued, and
//   compared when data_resultRDY pulses.
// -----------------------------------------------------------------------------
module tb_sll_iter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               ctrl_shift = 1'b0;
  logic [WIDTH-1:0]   A = '0;
  logic [SHAMT_W-1:0] shft_amount = '0;
  logic [WIDTH-1:0]   data_result;
  logic               data_exception;
  logic               data_resultRDY;
  logic               busy;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rdy_count = 0;
  int          n_rdy;
  logic [31:0] last_res = '0;
  logic        last_exc = 1'b0;

  sll_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .A              (A),
    .shft_amount    (shft_amount),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [4:0] s);
    logic [63:0] w;
    exp_t        e;
    w = {32'b0, a} << s;
    e.res     = w[31:0];
    e.exc     = |w[63:32];
    e.acc_cyc = 0;
    return e;
  endfunction

  // Completion monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && data_resultRDY) begin
      rdy_count++;
      if (sb.size() == 0) begin
        check("unexpected_rdy", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", 64'(data_result), 64'(e.res));
        check("exception", 64'(data_exception), 64'(e.exc));
        check("latency", 64'(cyc - e.acc_cyc), 64'd5);
        last_res = e.res;
        last_exc = e.exc;
      end
    end
  end

  // Drives a start, returns #1 after the accepting edge, and scrambles the
  // operand inputs so late sampling would be caught.
  task automatic start(input logic [31:0] a, input logic [4:0] s);
    exp_t e;
    @(negedge clock);
    ctrl_shift  = 1'b1;
    A           = a;
    shft_amount = s;
    @(posedge clock);
    #1;
    ctrl_shift  = 1'b0;
    A           = $urandom;
    shft_amount = 5'($urandom);
    e = model(a, s);
    e.acc_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_result", 64'(data_result), 64'd0);
    check("rst_exception", 64'(data_exception), 64'd0);
    check("rst_rdy", 64'(data_resultRDY), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Basic shift with busy/RDY timing
    start(32'h0000_00F1, 5'd8);
    check("busy_e0", 64'(busy), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      #1;
      check("busy_mid", 64'(busy), 64'd1);
      check("rdy_early", 64'(data_resultRDY), 64'd0);
    end
    @(posedge clock);
    #1;
    check("busy_done", 64'(busy), 64'd0);
    check("rdy_e5", 64'(data_resultRDY), 64'd1);
    check("basic_value", 64'(data_result), 64'h0000_F100);
    drain();

    // Zero / max amounts, overflow boundaries
    start(32'hDEAD_BEEF, 5'd0);  drain();
    start(32'h0000_0003, 5'd31); drain();
    start(32'h4000_0000, 5'd1);  drain();
    start(32'h4000_0000, 5'd2);  drain();
    check("ovf_amt2_exc", 64'(last_exc), 64'd1);

    // Restart at E2: only the second op completes
    n_rdy = rdy_count;
    start(32'h0000_1234, 5'd1);
    @(posedge clock);
    void'(sb.pop_back());
    start(32'h0000_0001, 5'd3);
    drain();
    check("restart_rdy_count", 64'(rdy_count - n_rdy), 64'd1);
    check("restart_value", 64'(last_res), 64'h8);

    // Back-to-back: second accept on the completing edge
    n_rdy = rdy_count;
    start(32'h0000_00AB, 5'd4);
    repeat (4) @(posedge clock);
    start(32'hF000_000F, 5'd4);
    check("b2b_rdy", 64'(data_resultRDY), 64'd1);
    check("b2b_busy", 64'(busy), 64'd1);
    drain();
    check("b2b_rdy_count", 64'(rdy_count - n_rdy), 64'd2);

    // Result hold with no further requests
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check("hold_result", 64'(data_result), 64'h0000_00F0);
      check("hold_exception", 64'(data_exception), 64'd1);
      check("hold_rdy", 64'(data_resultRDY), 64'd0);
    end

    // Reset mid-operation
    start(32'h0000_0001, 5'd4);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_result", 64'(data_result), 64'd0);
    check("rst_mid_exception", 64'(data_exception), 64'd0);
    check("rst_mid_rdy", 64'(data_resultRDY), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    void'(sb.pop_back());
    n_rdy = rdy_count;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("rst_mid_no_rdy", 64'(rdy_count - n_rdy), 64'd0);
    check("rst_mid_idle", 64'(busy), 64'd0);

    // Random operations
    for (int i = 0; i < 20; i++) begin
      start($urandom, 5'($urandom));
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sll_iter
